// File: rtl/sm4_pkg.sv
// rtl/sm4_pkg.sv - shared SM4 result-drain widths and FSM state encodings
package sm4_pkg;

    localparam int SM4_BLK_W  = 384;
    localparam int SM4_WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } sm4_state_e;

endpackage

// File: rtl/sm4_blk_fifo2.sv
// rtl/sm4_blk_fifo2.sv - two-entry block buffer with push/pop/count/full
module sm4_blk_fifo2 #(
    parameter int W = 384
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    // a push into a full buffer or a pop from an empty one is ignored
    assign w_push  = i_push && (r_count != 2'd2);
    assign w_pop   = i_pop  && (r_count != 2'd0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

    // payload storage; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // pointer and occupancy tracking; simultaneous push and pop keeps count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sm4_result_drain.sv
// rtl/sm4_result_drain.sv - buffers SM4 result blocks and streams them as words; WORD_SWAP_EN selects LSW-first order
module sm4_result_drain
    import sm4_pkg::*;
#(
    parameter int DATA_W = SM4_BLK_W,
    parameter int OUT_W  = SM4_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sm4_dout,
    input  logic              one_round_ok,
    input  logic              all_en_ok,
    output logic [OUT_W-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              send_ok,
    output logic              out_ok,
    output logic [31:0]       blk_cnt,
    output logic              ovf_err,
    output logic              drain_done
);

    localparam int NWORDS = DATA_W / OUT_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NWORDS - 1);
    localparam logic [IDX_W-1:0] LAST_M1_IDX = IDX_W'((NWORDS > 1) ? NWORDS - 2 : 0);

    sm4_state_e        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_idx;
    logic              r_aen_hist;
    logic              r_job_end;

    logic [DATA_W-1:0] w_head;
    logic [1:0]        w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_accept;
    logic              w_last_accept;
    logic [DATA_W-1:0] w_shift_next;

    assign w_push        = one_round_ok && !w_full;
    assign w_accept      = m_valid && m_ready;
    assign w_last_accept = (r_state == ST_SEND) && w_accept && (r_idx == LAST_IDX);
    // the head leaves the buffer the moment the shifter is free to take it
    assign w_pop         = !w_empty && ((r_state == ST_IDLE) || w_last_accept);

`ifdef WORD_SWAP_EN
    assign m_data       = r_shift[OUT_W-1:0];
    assign w_shift_next = {{OUT_W{1'b0}}, r_shift[DATA_W-1:OUT_W]};
`else
    assign m_data       = r_shift[DATA_W-1 -: OUT_W];
    assign w_shift_next = {r_shift[DATA_W-OUT_W-1:0], {OUT_W{1'b0}}};
`endif

    sm4_blk_fifo2 #(.W(DATA_W)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (sm4_dout),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // word-emission FSM: load a block, walk its words under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            out_ok  <= 1'b0;
            blk_cnt <= '0;
        end else begin
            out_ok <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_idx   <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    m_valid <= 1'b1;
                    m_last  <= (NWORDS == 1);
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_last_accept) begin
                        out_ok  <= 1'b1;
                        blk_cnt <= blk_cnt + 32'd1;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_idx   <= '0;
                            r_state <= ST_LOAD;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_accept) begin
                        r_shift <= w_shift_next;
                        r_idx   <= r_idx + 1'b1;
                        m_last  <= (r_idx == LAST_M1_IDX);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // capture acknowledge, overflow and end-of-job tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            send_ok    <= 1'b0;
            ovf_err    <= 1'b0;
            r_aen_hist <= 1'b1;
            r_job_end  <= 1'b0;
            drain_done <= 1'b0;
        end else begin
            send_ok    <= w_push;
            r_aen_hist <= all_en_ok;
            if (one_round_ok && w_full)        ovf_err   <= 1'b1;
            if (r_aen_hist && !all_en_ok)      r_job_end <= 1'b1;
            if (r_job_end && w_empty && (r_state == ST_IDLE)) drain_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sm4_result_drain.sv
// tb/tb_sm4_result_drain.sv - self-checking bench for sm4_result_drain
module tb_sm4_result_drain;

    localparam int DW = 384;
    localparam int OW = 32;
    localparam int NW = DW / OW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] sm4_dout;
    logic          one_round_ok;
    logic          all_en_ok;
    logic [OW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          send_ok;
    logic          out_ok;
    logic [31:0]   blk_cnt;
    logic          ovf_err;
    logic          drain_done;

    int n_assert = 0;
    int n_fail   = 0;
    int ready_mode = 0;

    logic [31:0] mon_q[$];
    logic        mon_last_q[$];
    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    int          n_send = 0;
    int          n_out = 0;
    int          n_stall_err = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    sm4_result_drain dut (
        .clk          (clk),
        .rst          (rst),
        .sm4_dout     (sm4_dout),
        .one_round_ok (one_round_ok),
        .all_en_ok    (all_en_ok),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .send_ok      (send_ok),
        .out_ok       (out_ok),
        .blk_cnt      (blk_cnt),
        .ovf_err      (ovf_err),
        .drain_done   (drain_done)
    );

    always #5 clk = ~clk;

    // observe accepted words, handshake pulses and stall stability
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            mon_q.push_back(m_data);
            mon_last_q.push_back(m_last);
        end
        if (send_ok) n_send++;
        if (out_ok)  n_out++;
        if (prev_stall && !rst && (!m_valid || m_data !== prev_data)) n_stall_err++;
        prev_stall = m_valid && !m_ready && !rst;
        prev_data  = m_data;
    end

    function automatic logic [31:0] ref_word(input logic [DW-1:0] blk, input int i);
`ifdef WORD_SWAP_EN
        return blk[i*OW +: OW];
`else
        return blk[DW-1 - i*OW -: OW];
`endif
    endfunction

    function automatic logic [DW-1:0] rand_blk();
        logic [DW-1:0] b;
        for (int i = 0; i < NW; i++) b[i*OW +: OW] = $urandom;
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    endtask

    task automatic expect_blk(input logic [DW-1:0] b);
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back(ref_word(b, i));
            exp_last_q.push_back(i == NW - 1);
        end
    endtask

    task automatic strobe(input logic [DW-1:0] b);
        sm4_dout = b;
        one_round_ok = 1'b1;
        tick();
        one_round_ok = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int cyc = 0;
        while (mon_q.size() < n && cyc < budget) begin
            tick();
            cyc++;
        end
        check("wait_words", 32'(mon_q.size()), 32'(n));
    endtask

    task automatic compare_stream(input string tag);
        logic [31:0] w, e;
        logic        l, el;
        check({tag, "_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
        while (mon_q.size() > 0 && exp_q.size() > 0) begin
            w  = mon_q.pop_front();
            l  = mon_last_q.pop_front();
            e  = exp_q.pop_front();
            el = exp_last_q.pop_front();
            check({tag, "_word"}, w, e);
            check({tag, "_last"}, 32'(l), 32'(el));
        end
        mon_q.delete();
        mon_last_q.delete();
        exp_q.delete();
        exp_last_q.delete();
    endtask

    initial begin
        logic [DW-1:0] blk;
        logic [DW-1:0] b4 [4];
        int exp_blk;
        int send0;
        int out0;

        rst = 1'b1;
        one_round_ok = 1'b0;
        all_en_ok = 1'b1;
        sm4_dout = '0;
        m_ready = 1'b1;
        exp_blk = 0;
        tick();
        tick();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_send_ok", 32'(send_ok), 32'd0);
        check("rst_out_ok", 32'(out_ok), 32'd0);
        check("rst_blk_cnt", blk_cnt, 32'd0);
        check("rst_ovf", 32'(ovf_err), 32'd0);
        check("rst_done", 32'(drain_done), 32'd0);
        rst = 1'b0;
        tick();
        tick();

        // single block, ready held high: exact latency
        for (int i = 0; i < NW; i++) blk[DW-1 - i*OW -: OW] = 32'(i + 1);
        expect_blk(blk);
        strobe(blk);
        check("t1_send_ok_T1", 32'(send_ok), 32'd1);
        check("t1_valid_T1", 32'(m_valid), 32'd0);
        tick();
        check("t1_send_ok_T2", 32'(send_ok), 32'd0);
        check("t1_valid_T2", 32'(m_valid), 32'd0);
        tick();
        check("t1_valid_T3", 32'(m_valid), 32'd1);
        check("t1_word0", m_data, ref_word(blk, 0));
        check("t1_last_T3", 32'(m_last), 32'd0);
        for (int i = 0; i < NW - 1; i++) tick();
        check("t1_last_T14", 32'(m_last), 32'd1);
        check("t1_word11", m_data, ref_word(blk, NW - 1));
        tick();
        check("t1_out_ok_T15", 32'(out_ok), 32'd1);
        check("t1_valid_T15", 32'(m_valid), 32'd0);
        exp_blk = 1;
        check("t1_blk_cnt", blk_cnt, 32'(exp_blk));
        tick();
        check("t1_out_ok_T16", 32'(out_ok), 32'd0);
        compare_stream("t1");

        // toggling ready: held data during stalls, no skips or repeats
        ready_mode = 1;
        blk = rand_blk();
        expect_blk(blk);
        strobe(blk);
        wait_words(NW, 200);
        tick(); tick(); tick();
        compare_stream("t2");
        exp_blk++;
        check("t2_blk_cnt", blk_cnt, 32'(exp_blk));
        check("t2_stall", 32'(n_stall_err), 32'd0);

        // back-to-back strobes with ready low: shifter plus two buffer slots, fourth dropped
        ready_mode = 3;
        m_ready = 1'b0;
        send0 = n_send;
        for (int k = 0; k < 4; k++) b4[k] = rand_blk();
        for (int k = 0; k < 3; k++) expect_blk(b4[k]);
        for (int k = 0; k < 4; k++) begin
            sm4_dout = b4[k];
            one_round_ok = 1'b1;
            tick();
        end
        one_round_ok = 1'b0;
        tick(); tick(); tick();
        check("t3_send_cnt", 32'(n_send - send0), 32'd3);
        check("t3_ovf", 32'(ovf_err), 32'd1);
        check("t3_valid_stalled", 32'(m_valid), 32'd1);
        check("t3_word0_stalled", m_data, ref_word(b4[0], 0));
        ready_mode = 0;
        m_ready = 1'b1;
        wait_words(3 * NW, 400);
        tick(); tick(); tick();
        compare_stream("t3");
        exp_blk += 3;
        check("t3_blk_cnt", blk_cnt, 32'(exp_blk));

        // random data, random ready, overlapping pairs of blocks
        ready_mode = 2;
        send0 = n_send;
        for (int it = 0; it < 8; it++) begin
            blk = rand_blk();
            expect_blk(blk);
            strobe(blk);
            repeat ($urandom_range(1, 10)) tick();
            blk = rand_blk();
            expect_blk(blk);
            strobe(blk);
            wait_words(2 * NW, 600);
            tick(); tick(); tick();
            compare_stream("rnd");
        end
        exp_blk += 16;
        check("rnd_send_cnt", 32'(n_send - send0), 32'd16);
        check("rnd_blk_cnt", blk_cnt, 32'(exp_blk));
        check("rnd_ovf_sticky", 32'(ovf_err), 32'd1);
        check("rnd_stall", 32'(n_stall_err), 32'd0);

        // strobe coincident with all_en_ok falling edge
        ready_mode = 0;
        m_ready = 1'b1;
        tick();
        check("t4_done_pre", 32'(drain_done), 32'd0);
        blk = rand_blk();
        expect_blk(blk);
        sm4_dout = blk;
        one_round_ok = 1'b1;
        all_en_ok = 1'b0;
        tick();
        one_round_ok = 1'b0;
        check("t4_done_early", 32'(drain_done), 32'd0);
        wait_words(NW, 100);
        check("t4_done_at_end", 32'(drain_done), 32'd0);
        tick();
        check("t4_done_set", 32'(drain_done), 32'd1);
        compare_stream("t4");
        exp_blk++;
        check("t4_blk_cnt", blk_cnt, 32'(exp_blk));
        repeat (5) tick();
        check("t4_done_sticky", 32'(drain_done), 32'd1);

        // reset while the fifth word is on the bus
        all_en_ok = 1'b1;
        blk = rand_blk();
        strobe(blk);
        wait_words(4, 100);
        check("t5_word4", m_data, ref_word(blk, 4));
        out0 = n_out;
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(m_valid), 32'd0);
        check("t5_rst_data", m_data, 32'd0);
        check("t5_rst_last", 32'(m_last), 32'd0);
        check("t5_rst_blk_cnt", blk_cnt, 32'd0);
        check("t5_rst_ovf", 32'(ovf_err), 32'd0);
        check("t5_rst_done", 32'(drain_done), 32'd0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("t5_no_out_ok", 32'(n_out - out0), 32'd0);
        check("t5_words_stopped", 32'(mon_q.size()), 32'd4);
        check("t5_blk_cnt_after", blk_cnt, 32'd0);
        check("t5_valid_after", 32'(m_valid), 32'd0);
        mon_q.delete();
        mon_last_q.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
